// File: rtl/add_seq_pkg.sv
// add_seq shared types: slice width, FSM state enum, index-width helper.
// No ports; imported by add_seq.
package add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_seq_state_t;

  // Width of the slice index; at least one bit so WORDS=1 still has a register.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add_seq_add16.sv
// add16: 16-bit ripple adder with carry in/out, shared by the sequencer.
// Ports: a, b, cin in; sum, cout out.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

// File: rtl/add_seq.sv
// add_seq: WORDS x 16-bit adder that reuses one add16, one slice per cycle.
// Ports: clk, rst (async high), in_valid/in_ready + A, B, Cin [, sub],
// out_valid/out_ready + Sum, Cout. Macro ADD_SEQ_SUB_EN adds sub (A-B).
module add_seq
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] A,
  input  logic [SLICE_W*WORDS-1:0] B,
  input  logic                     Cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] Sum,
  output logic                     Cout
);

  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  add_seq_state_t state;

  logic [WORDS-1:0][SLICE_W-1:0] a_q;
  logic [WORDS-1:0][SLICE_W-1:0] b_q;
  logic [WORDS-1:0][SLICE_W-1:0] sum_q;
  logic [IW-1:0]                 idx;
  logic                          carry;
  logic                          cout_q;

  logic [SLICE_W-1:0] a_op;
  logic [SLICE_W-1:0] b_op;
  logic [SLICE_W-1:0] s_slice;
  logic               c_slice;
  logic               c_init;

  assign a_op = a_q[idx];

`ifdef ADD_SEQ_SUB_EN
  logic sub_q;

  // Two's complement subtract: invert B and force carry-in to 1.
  assign b_op   = b_q[idx] ^ {SLICE_W{sub_q}};
  assign c_init = sub | Cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sub_q <= sub;
    end
  end
`else
  assign b_op   = b_q[idx];
  assign c_init = Cin;
`endif

  add16 u_add16 (
    .a    (a_op),
    .b    (b_op),
    .cin  (carry),
    .sum  (s_slice),
    .cout (c_slice)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            idx   <= '0;
            carry <= c_init;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= s_slice;
          carry      <= c_slice;
          if (idx == LAST) begin
            cout_q <= c_slice;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq (WORDS=4): directed cases plus random ops
// checked against a plain-arithmetic model of the wide add.
module tb_add_seq;

  localparam int WORDS = 4;
  localparam int W = 16 * WORDS;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Sum;
  logic         Cout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, b,
                                       input logic c, s);
    logic [W:0] r;
`ifdef ADD_SEQ_SUB_EN
    if (s) return {1'b0, a} + {1'b0, ~b} + 1;
`endif
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, data on handshake.
  initial begin
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            chk("latency", W'(cyc - sb[0].acc), W'(WORDS));
          end
        end
        if (out_valid && out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("sum", Sum, e.sum);
          chk("cout", W'(Cout), W'(e.cout));
        end
      end
      prev_ov = out_valid;
    end
  end

  // Called at #1 after a rising edge.
  task automatic send(input logic [W-1:0] a, b, input logic c, s);
    int n;
    logic [W:0] m;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      return;
    end
    A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom;
    m = model(a, b, c, s);
    sb.push_back('{sum: m[W-1:0], cout: m[W], acc: cyc});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", W'(sb.size()), 0);
      sb.delete();
    end
  endtask

  initial begin
    logic [W:0] m;
    int n;
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [W:0] m;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_sum", Sum, 0);
    chk("rst_cout", W'(Cout), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    drain();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    drain();

    // Back-pressure with an ignored request during DONE.
    out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    m = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_out_valid", W'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      A = 64'hDEAD; B = 64'hBEEF; in_valid = 1'b1;
      chk("bp_sum", Sum, m[W-1:0]);
      chk("bp_cout", W'(Cout), W'(m[W]));
      chk("bp_in_ready", W'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", W'(in_ready), 1);
    drain();
    repeat (8) @(posedge clk);
    #1;

    // Reset on the second RUN cycle.
    send(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_in_ready", W'(in_ready), 1);
    chk("mid_rst_out_valid", W'(out_valid), 0);
    chk("mid_rst_sum", Sum, 0);
    chk("mid_rst_cout", W'(Cout), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(64'h3, 64'h4, 1'b0, 1'b0);
    drain();

`ifdef ADD_SEQ_SUB_EN
    send(64'h1_0000, 64'h1, 1'b0, 1'b1);
    drain();
    send(64'h0, 64'h1, 1'b1, 1'b1);
    drain();
`endif

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'b0;
`ifdef ADD_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      out_ready = 1'($urandom_range(0, 3) != 0);
      send(ra, rb, 1'($urandom_range(0, 1)), rs);
      n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk); #1; n++;
        out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      drain();
    end

    repeat (10) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_seq.md
# add_seq

Multi-cycle wide adder sequencer. It accepts WORDS×16-bit operands over a valid/ready handshake and feeds them one 16-bit slice per cycle, least-significant slice first, through a single shared `add16` instance. The slice carry is held in a register between cycles. It returns the full sum and carry-out over a second valid/ready handshake. It sits in front of `add16` wherever the datapath needs adds wider than 16 bits without replicating adder hardware.

## Interface
- `WORDS`, default 4: number of 16-bit slices; operand width W = 16·WORDS; legal range 1..16.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `in_valid` input, 1: operand request.
- `in_ready` output, 1: block can accept a request.
- `A` input, W: operand A.
- `B` input, W: operand B.
- `Cin` input, 1: carry into slice 0.
- `sub` input, 1: subtract select. Exists only with `ADD_SEQ_SUB_EN`.
- `out_valid` output, 1: result available.
- `out_ready` input, 1: consumer accepts the result.
- `Sum` output, W: result.
- `Cout` output, 1: carry out of the top slice.

## Operation
- The FSM has three states: IDLE, RUN, DONE. The reset state is IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready` at a rising edge, latch A, B and Cin (and `sub`).
  - Set the slice index to 0 and the carry register to Cin, then go to RUN.
- **RUN:** each cycle:
  - Apply `add16` to A slice[idx], B slice[idx] and the carry register.
  - Write the sum into Sum slice[idx] and load the carry register with the slice Cout.
  - If idx==WORDS-1, go to DONE. Otherwise idx+1.
- **DONE:**
  - `out_valid`=1; `Sum` and `Cout` are stable.
  - On `out_ready`=1 at an edge, go to IDLE.
- `in_ready` is high only in IDLE. `in_valid` in RUN or DONE is ignored, not queued.
- `out_valid` is high only in DONE.
- Arithmetic is modulo 2^W. `Cout` is the carry from bit W-1. No overflow flag.
- Latched operands stay constant for the whole operation, so the caller may change `A`/`B` after the accept edge.
- `Sum` is updated slice by slice during RUN and is only meaningful while `out_valid`=1.
- **Reset values:** `in_ready`=1 (IDLE), `out_valid`=0, `Sum`=0, `Cout`=0; the carry register and idx are 0.
- **Reset mid-operation:** `rst` in RUN or DONE aborts immediately. Outputs take their reset values asynchronously and the partial result is discarded.
- **WORDS=1:** RUN lasts exactly one cycle.

## Timing
- The accept edge is T0. RUN occupies edges T1..T_WORDS. `out_valid` rises after edge T_WORDS, which is a latency of WORDS cycles from accept to `out_valid`.
- With `out_ready` held at 1, `out_valid` lasts one cycle. `in_ready` returns the cycle after the result handshake.
- Minimum initiation interval is WORDS+2 cycles.
- `out_valid`, `Sum`, `Cout` and `in_ready` are registered or decoded purely from state, with no combinational path from `in_valid` or `out_ready`.
- The only combinational logic is one `add16` pass plus the slice mux per cycle.

## Configuration
- Macro `ADD_SEQ_SUB_EN`.
- **Defined:**
  - Port `sub` exists and is latched at accept.
  - When `sub`=1, every B slice is inverted before `add16` and the initial carry is forced to 1, ignoring `Cin`. The result is A−B mod 2^W, and `Cout`=1 means no borrow.
  - When `sub`=0, behaviour is identical to the undefined case.
- **Undefined:** no `sub` port and no inversion logic; the block is add only.

## Structure
- Package `add_seq_pkg` holds:
  - `localparam SLICE_W = 16`.
  - The state enum `add_seq_state_t` {IDLE, RUN, DONE}.
  - The idx width helper (clog2 of WORDS, minimum 1).
- One sub-module: the existing `add16`, instantiated once, named `u_add16`.
- The slice mux, B inversion, carry register and FSM stay in `add_seq`.

## Test plan
All scenarios use WORDS=4.
- **Reset:** assert `rst` with no traffic → `in_ready`=1, `out_valid`=0, `Sum`=0, `Cout`=0.
- **Carry across a slice boundary:** A=0x0000_0000_0000_FFFF, B=0x1, Cin=0, `out_ready`=1 → `out_valid` exactly 4 cycles after accept; `Sum`=0x0000_0000_0001_0000, `Cout`=0.
- **Full ripple:** A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 → `Sum`=0, `Cout`=1.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles after `out_valid` → `Sum`/`Cout` held and `in_ready`=0. A concurrent `in_valid` with new operands is ignored. After `out_ready`=1, `in_ready`=1 on the next cycle.
- **Reset mid-RUN:** pulse `rst` on the second RUN cycle → immediate IDLE and reset outputs. The next op, A=3, B=4, gives `Sum`=7.
- **With `ADD_SEQ_SUB_EN`:**
  - `sub`=1, A=0x1_0000, B=1 → `Sum`=0xFFFF, `Cout`=1.
  - `sub`=1, A=0, B=1 → `Sum`=0xFFFF_FFFF_FFFF_FFFF, `Cout`=0.
